// File: rtl/shift_sched_pkg.sv
// Shared encodings and helpers for the shift scheduler.
// State values are fixed so the encoding stays stable across tools.
package shift_sched_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int unsigned SHAMT_BITS = 5;

  typedef enum logic [1:0] {
    StIdle = S_IDLE,
    StExec = S_EXEC,
    StResp = S_RESP
  } state_e;

  // A shift of 32 or more clears every bit, so the shifter result is discarded.
  function automatic logic shamt_overflow(input logic [31:0] b);
    return |b[31:SHAMT_BITS];
  endfunction

endpackage

// File: rtl/shift_scheduler_if.sv
// Request/response bundle between two issuing stages, one consumer and the shift scheduler.
// The slave modport is the scheduler's view; master is the requester/consumer side.
interface shift_scheduler_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
);

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH-1:0] resp_data;

  logic             busy;
  logic [CNT_W-1:0] done_count;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_data,
    output busy, done_count
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_data,
    input  busy, done_count
  );

endinterface

// File: rtl/shiftLeft.sv
// Existing combinational 32-bit left shifter shared by the ALU requesters.
module shiftLeft (
  output logic [31:0] out,
  input  logic [31:0] A,
  input  logic [4:0]  B
);

  assign out = A << B;

endmodule

// File: rtl/shift_scheduler.sv
// Round-robin scheduler sharing one shiftLeft between two requesters.
// Accept in IDLE, shift in EXEC, hold the registered result in RESP until consumed.
module shift_scheduler
  import shift_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_scheduler_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic             last_grant_q, last_grant_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic [CNT_W-1:0] done_count_q, done_count_d;

  logic             grant0, grant1;
  logic [WIDTH-1:0] shift_out;

  // Round-robin: under contention the requester not served last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == StIdle) begin
      grant0 = bus.req0_valid & (~bus.req1_valid | last_grant_q);
      grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
    end
  end

  shiftLeft u_shift_left (
    .out (shift_out),
    .A   (a_q),
    .B   (b_q[SHAMT_BITS-1:0])
  );

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    done_count_d = done_count_q;

    unique case (state_q)
      StIdle: begin
        if (grant0 | grant1) begin
          a_d     = grant1 ? bus.req1_a : bus.req0_a;
          b_d     = grant1 ? bus.req1_b : bus.req0_b;
          id_d    = grant1;
          state_d = StExec;
        end
      end
      StExec: begin
        resp_data_d  = shamt_overflow(b_q) ? '0 : shift_out;
        resp_id_d    = id_q;
        last_grant_d = id_q;
        resp_valid_d = 1'b1;
        state_d      = StResp;
      end
      StResp: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          done_count_d = done_count_q + CNT_W'(1);
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
      done_count_q <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      done_count_q <= done_count_d;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.done_count = done_count_q;

endmodule

// File: tb/tb_shift_scheduler.sv
// Directed bench for shift_scheduler: single requesters, shift boundaries,
// arbitration, backpressure and reset during an operation.
module tb_shift_scheduler;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  shift_scheduler_if #(.WIDTH(32), .CNT_W(16)) bus ();

  shift_scheduler #(.WIDTH(32), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one op from a single requester, wait (bounded) for accept and response.
  task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b,
                       output int wait_cyc, output int lat,
                       output logic [31:0] data, output logic rid);
    @(negedge clk);
    bus.req0_valid = ~id; bus.req0_a = a; bus.req0_b = b;
    bus.req1_valid = id;  bus.req1_a = a; bus.req1_b = b;
    bus.resp_ready = 1'b1;
    wait_cyc = -1; lat = -1; data = '0; rid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (id ? bus.req1_ready : bus.req0_ready) begin
        wait_cyc = c;
        break;
      end
      @(negedge clk);
    end
    if (wait_cyc >= 0) @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    if (wait_cyc >= 0) begin
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        if (bus.resp_valid) begin
          lat = c; data = bus.resp_data; rid = bus.resp_id;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
    bus.resp_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
    checks++; if (bus.resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data: got %h want 0", bus.resp_data); end
    checks++; if (bus.resp_id !== 1'b0) begin errors++; $display("FAIL reset_resp_id: got %b want 0", bus.resp_id); end
    checks++; if (bus.done_count !== 16'd0) begin errors++; $display("FAIL reset_done_count: got %0d want 0", bus.done_count); end
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready_idle: got %b want 00", {bus.req0_ready, bus.req1_ready}); end
  endtask

  task automatic test_req0_only();
    int w, l; logic [31:0] d; logic r;
    issue(1'b0, 32'h1, 32'd2, w, l, d, r);
    checks++; if (w !== 0) begin errors++; $display("FAIL req0_accept_wait: got %0d want 0", w); end
    checks++; if (l !== 2) begin errors++; $display("FAIL req0_latency: got %0d want 2", l); end
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL req0_data: got %h want 00000004", d); end
    checks++; if (r !== 1'b0) begin errors++; $display("FAIL req0_id: got %b want 0", r); end
    @(negedge clk);
    checks++; if (bus.done_count !== 16'd1) begin errors++; $display("FAIL req0_done_count: got %0d want 1", bus.done_count); end
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL req0_resp_cleared: got %b want 0", bus.resp_valid); end
  endtask

  task automatic test_req1_only();
    int w, l; logic [31:0] d; logic r;
    issue(1'b1, 32'hFFFF_FFFF, 32'd1, w, l, d, r);
    checks++; if (d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL req1_data_a: got %h want fffffffe", d); end
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL req1_id_a: got %b want 1", r); end
    issue(1'b1, 32'h1, 32'd8, w, l, d, r);
    checks++; if (d !== 32'h100) begin errors++; $display("FAIL req1_data_b: got %h want 00000100", d); end
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL req1_id_b: got %b want 1", r); end
    @(negedge clk);
    checks++; if (bus.done_count !== 16'd3) begin errors++; $display("FAIL req1_done_count: got %0d want 3", bus.done_count); end
  endtask

  task automatic test_shift_boundaries();
    int w, l; logic [31:0] d; logic r;
    logic [63:0] wide;
    logic [31:0] in_a [5];
    logic [31:0] in_b [5];
    logic [31:0] exp_d [5];
    wide = 64'h1_0000_0001;
    in_a[0] = 32'h1;         in_b[0] = 32'd31;        exp_d[0] = 32'h8000_0000;
    in_a[1] = 32'h1;         in_b[1] = 32'd32;        exp_d[1] = 32'h0;
    in_a[2] = 32'h3;         in_b[2] = wide[31:0];    exp_d[2] = 32'h6;
    in_a[3] = 32'h1;         in_b[3] = 32'h8000_0000; exp_d[3] = 32'h0;
    in_a[4] = 32'hABCD_1234; in_b[4] = 32'd0;         exp_d[4] = 32'hABCD_1234;
    for (int i = 0; i < 5; i++) begin
      issue(i[0], in_a[i], in_b[i], w, l, d, r);
      checks++;
      if (d !== exp_d[i])
        begin errors++; $display("FAIL shamt_%0d: b=%h got %h want %h", i, in_b[i], d, exp_d[i]); end
    end
  endtask

  task automatic test_arbitration();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 32'h1; bus.req0_b = 32'd4;
    bus.req1_valid = 1'b1; bus.req1_a = 32'h1; bus.req1_b = 32'd3;
    bus.resp_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL arb_first_grant: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
    @(negedge clk);
    checks++; if ({bus.busy, bus.req0_ready, bus.req1_ready} !== 3'b100) begin errors++; $display("FAIL arb_exec_ready: got %b want 100", {bus.busy, bus.req0_ready, bus.req1_ready}); end
    @(negedge clk);
    checks++; if ({bus.resp_valid, bus.resp_id, bus.resp_data} !== {2'b10, 32'h10}) begin errors++; $display("FAIL arb_resp0: got v%b id%b %h want v1 id0 00000010", bus.resp_valid, bus.resp_id, bus.resp_data); end
    @(negedge clk);
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin errors++; $display("FAIL arb_second_grant: got %b want 01", {bus.req0_ready, bus.req1_ready}); end
    checks++; if (bus.done_count !== 16'd1) begin errors++; $display("FAIL arb_count1: got %0d want 1", bus.done_count); end
    @(negedge clk); @(negedge clk);
    checks++; if ({bus.resp_valid, bus.resp_id, bus.resp_data} !== {2'b11, 32'h8}) begin errors++; $display("FAIL arb_resp1: got v%b id%b %h want v1 id1 00000008", bus.resp_valid, bus.resp_id, bus.resp_data); end
    @(negedge clk);
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL arb_third_grant: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
    bus.req1_valid = 1'b0;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    checks++; if ({bus.resp_valid, bus.resp_id, bus.resp_data} !== {2'b10, 32'h10}) begin errors++; $display("FAIL arb_resp2: got v%b id%b %h want v1 id0 00000010", bus.resp_valid, bus.resp_id, bus.resp_data); end
    @(negedge clk);
    checks++; if (bus.done_count !== 16'd3) begin errors++; $display("FAIL arb_count3: got %0d want 3", bus.done_count); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_a = 32'h5; bus.req0_b = 32'd1;
    bus.req1_valid = 1'b1; bus.req1_a = 32'h7; bus.req1_b = 32'd2;
    bus.resp_ready = 1'b0;
    #1;
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin errors++; $display("FAIL bp_grant: got %b want 01", {bus.req0_ready, bus.req1_ready}); end
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.resp_valid, bus.resp_id, bus.resp_data, bus.req0_ready, bus.req1_ready} !== {2'b11, 32'h1C, 2'b00})
        begin errors++; $display("FAIL bp_hold_%0d: got v%b id%b %h rdy%b%b want v1 id1 0000001c rdy00", i, bus.resp_valid, bus.resp_id, bus.resp_data, bus.req0_ready, bus.req1_ready); end
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    checks++; if ({bus.resp_valid, bus.req0_ready, bus.req1_ready} !== 3'b010) begin errors++; $display("FAIL bp_release: got %b want 010", {bus.resp_valid, bus.req0_ready, bus.req1_ready}); end
    checks++; if (bus.done_count !== 16'd4) begin errors++; $display("FAIL bp_count: got %0d want 4", bus.done_count); end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_a = 32'h1; bus.req0_b = 32'd4;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_mid_exec: got busy %b want 1", bus.busy); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.resp_valid, bus.resp_id, bus.resp_data, bus.done_count} !== {3'b000, 32'h0, 16'd0})
      begin errors++; $display("FAIL rst_mid_clear: got busy%b v%b id%b %h cnt%0d want all 0", bus.busy, bus.resp_valid, bus.resp_id, bus.resp_data, bus.done_count); end
    @(negedge clk);
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_no_resp: got %b want 0", bus.resp_valid); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_pending_ready: got %b want 1", bus.req0_ready); end
    @(negedge clk);
    checks++; if ({bus.busy, bus.resp_valid} !== 2'b10) begin errors++; $display("FAIL rst_mid_reaccept: got %b want 10", {bus.busy, bus.resp_valid}); end
    bus.req0_valid = 1'b0;
    @(negedge clk);
    checks++; if ({bus.resp_valid, bus.resp_id, bus.resp_data} !== {2'b10, 32'h10}) begin errors++; $display("FAIL rst_mid_resp: got v%b id%b %h want v1 id0 00000010", bus.resp_valid, bus.resp_id, bus.resp_data); end
    @(negedge clk);
    checks++; if (bus.done_count !== 16'd1) begin errors++; $display("FAIL rst_mid_count: got %0d want 1", bus.done_count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_req0_only();
    test_req1_only();
    test_shift_boundaries();
    test_arbitration();
    test_backpressure();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
